csa_seq_adder: RTL and testbench

Parametrised multi-cycle carry-select adder/subtractor for the ALU datapath. It processes one BLOCK-bit carry-select slice per clock, LSB block first, and threads the carry between cycles in a register. A start/busy/done handshake controls it, and it reports sum, carry-out and signed overflow. It extends the 2-bit carry-select adder to arbitrary width, adds subtract mode and adds sequential control.

---
 rtl/csa_seq_adder_pkg.sv | 29 ++
 rtl/csa_block.sv | 50 +++++
 rtl/csa_seq_adder.sv | 160 ++++++++++++++++
 tb/tb_csa_seq_adder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_seq_adder_pkg.sv
// ============================================================================
// Module      : csa_seq_adder_pkg
// Description : Shared definitions for the sequential carry-select adder:
//               FSM state encoding, op-mode constants and index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csa_seq_adder_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operation select values for the sub input
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width of the slice index counter; at least one bit even for one slice
  function automatic int idx_width(input int nblk);
    return (nblk > 1) ? $clog2(nblk) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/csa_block.sv
// ============================================================================
// Module      : csa_block
// Description : Combinational carry-select slice. Two ripple chains are
//               evaluated for carry-in 0 and 1; the real carry-in picks one.
//               c_msb is the carry into the slice MSB, used for overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_block
  import csa_seq_adder_pkg::*;
#(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [BLOCK-1:0] sum0;
  logic [BLOCK-1:0] sum1;
  logic [BLOCK:0]   c0;
  logic [BLOCK:0]   c1;

  // Both speculative ripple chains, one per assumed carry-in
  always_comb begin
    sum0  = '0;
    sum1  = '0;
    c0    = '0;
    c1    = '0;
    c0[0] = 1'b0;
    c1[0] = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      sum0[i]  = a[i] ^ b[i] ^ c0[i];
      c0[i+1]  = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      sum1[i]  = a[i] ^ b[i] ^ c1[i];
      c1[i+1]  = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  assign sum   = cin ? sum1 : sum0;
  assign cout  = cin ? c1[BLOCK] : c0[BLOCK];
  assign c_msb = cin ? c1[BLOCK-1] : c0[BLOCK-1];

endmodule

`default_nettype wire

// File: rtl/csa_seq_adder.sv
// ============================================================================
// Module      : csa_seq_adder
// Description : Multi-cycle carry-select adder/subtractor. One BLOCK-bit
//               slice is processed per clock, LSB first, with the carry
//               threaded through a register. start/busy/done handshake;
//               reports sum, carry-out and signed overflow.
//               WIDTH must be a multiple of BLOCK.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_seq_adder
  import csa_seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int                NBLK       = WIDTH / BLOCK;
  localparam int                IDXW       = idx_width(NBLK);
  localparam logic [IDXW-1:0]   LAST_IDX   = IDXW'(NBLK - 1);
  localparam logic [WIDTH-1:0]  SLICE_MASK = WIDTH'({BLOCK{1'b1}});

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic              load;
  logic              last;
  logic [31:0]       ofs;
  logic [WIDTH-1:0]  opa_sh;
  logic [WIDTH-1:0]  opb_sh;
  logic [BLOCK-1:0]  blk_sum;
  logic              blk_cout;
  logic              blk_cmsb;

  // Bit offset of the current slice; shifting avoids a variable part-select
  assign ofs    = 32'(idx_q) * 32'(BLOCK);
  assign opa_sh = opa_q >> ofs;
  assign opb_sh = opb_q >> ofs;
  assign last   = (idx_q == LAST_IDX);

  csa_block #(
    .BLOCK (BLOCK)
  ) u_blk (
    .a     (opa_sh[BLOCK-1:0]),
    .b     (opb_sh[BLOCK-1:0]),
    .cin   (carry_q),
    .sum   (blk_sum),
    .cout  (blk_cout),
    .c_msb (blk_cmsb)
  );

  // Next-state logic; load marks the cycle operands are captured
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, per-slice accumulate, result publish on last slice
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (load) begin
      // Subtract is a + ~b + !borrow_in
      opa_d   = a;
      opb_d   = (sub == OP_SUB) ? ~b : b;
      carry_d = (sub == OP_SUB) ? ~cin : cin;
      idx_d   = '0;
    end else if (state_q == ST_RUN) begin
      acc_d   = (acc_q & ~(SLICE_MASK << ofs)) | (WIDTH'(blk_sum) << ofs);
      carry_d = blk_cout;
      idx_d   = last ? '0 : idx_q + 1'b1;
      if (last) begin
        sum_d  = acc_d;
        cout_d = blk_cout;
        ovf_d  = blk_cmsb ^ blk_cout;
      end
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_csa_seq_adder.sv
// ============================================================================
// Module      : tb_csa_seq_adder
// Description : Self-checking bench for csa_seq_adder. Four instances:
//               16/4, 8/8, 8/1, 32/4. Directed table, handshake corner
//               sequences and randomized ops against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa_seq_adder;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        start_v [4];
  logic        sub_v   [4];
  logic        cin_v   [4];
  logic [31:0] a_v     [4];
  logic [31:0] b_v     [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic        cout_v  [4];
  logic        ovf_v   [4];
  logic [15:0] sum0;
  logic [7:0]  sum1;
  logic [7:0]  sum2;
  logic [31:0] sum3;

  int wid [4] = '{16, 8, 8, 32};
  int nbk [4] = '{4, 1, 8, 8};

  csa_seq_adder #(.WIDTH(16), .BLOCK(4)) u_w16b4 (
    .clock(clock), .reset_n(reset_n), .start(start_v[0]), .sub(sub_v[0]),
    .a(a_v[0][15:0]), .b(b_v[0][15:0]), .cin(cin_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .sum(sum0), .cout(cout_v[0]), .overflow(ovf_v[0]));

  csa_seq_adder #(.WIDTH(8), .BLOCK(8)) u_w8b8 (
    .clock(clock), .reset_n(reset_n), .start(start_v[1]), .sub(sub_v[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .sum(sum1), .cout(cout_v[1]), .overflow(ovf_v[1]));

  csa_seq_adder #(.WIDTH(8), .BLOCK(1)) u_w8b1 (
    .clock(clock), .reset_n(reset_n), .start(start_v[2]), .sub(sub_v[2]),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .sum(sum2), .cout(cout_v[2]), .overflow(ovf_v[2]));

  csa_seq_adder #(.WIDTH(32), .BLOCK(4)) u_w32b4 (
    .clock(clock), .reset_n(reset_n), .start(start_v[3]), .sub(sub_v[3]),
    .a(a_v[3]), .b(b_v[3]), .cin(cin_v[3]), .busy(busy_v[3]),
    .done(done_v[3]), .sum(sum3), .cout(cout_v[3]), .overflow(ovf_v[3]));

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] sum_of(input int k);
    case (k)
      0:       return 32'(sum0);
      1:       return 32'(sum1);
      2:       return 32'(sum2);
      default: return sum3;
    endcase
  endfunction

  // Reference: unsigned and signed integer arithmetic on the whole word
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic s, input logic c,
                                output logic [31:0] es, output logic ec, output logic eo);
    longint ua, ub, lc, lim, sa, sb, full, exact;
    ua    = longint'({32'd0, a});
    ub    = longint'({32'd0, b});
    lc    = c ? 1 : 0;
    lim   = longint'(1) << (w - 1);
    sa    = (ua >= lim) ? ua - 2 * lim : ua;
    sb    = (ub >= lim) ? ub - 2 * lim : ub;
    if (!s) begin
      full  = ua + ub + lc;
      exact = sa + sb + lc;
      ec    = (full >= 2 * lim);
    end else begin
      full  = ua - ub - lc;
      exact = sa - sb - lc;
      ec    = (ua >= ub + lc);   // raw carry: 1 means no borrow
    end
    es = 32'(full & (2 * lim - 1));
    eo = (exact >= lim) || (exact < -lim);
  endfunction

  function automatic logic [31:0] rnd_val(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'd1 << (w - 1);
      3:       return (32'd1 << (w - 1)) - 32'd1;
      default: return $urandom() & m;
    endcase
  endfunction

  task automatic drive(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic c);
    a_v[k]   = a;
    b_v[k]   = b;
    sub_v[k] = s;
    cin_v[k] = c;
  endtask

  // Called at a negedge; counts busy cycles until done or budget runs out
  task automatic wait_done(input int k, output int nb, output bit ok);
    nb = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_v[k]) begin
        ok = 1'b1;
        break;
      end
      if (busy_v[k]) nb++;
      @(negedge clock);
    end
  endtask

  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c,
                        output logic [31:0] rs, output logic rc, output logic ro,
                        output int nb, output bit ok);
    @(negedge clock);
    drive(k, a, b, s, c);
    start_v[k] = 1'b1;
    @(negedge clock);
    start_v[k] = 1'b0;
    wait_done(k, nb, ok);
    rs = sum_of(k);
    rc = cout_v[k];
    ro = ovf_v[k];
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic        c;
    logic [15:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] rs, ea, eb, es;
    logic        rc, ro, ec, eo, rsub, rcin;
    int          nb, dcnt, bcnt;
    bit          ok;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};

    for (int k = 0; k < 4; k++) begin
      start_v[k] = 1'b0;
      drive(k, 32'd0, 32'd0, 1'b0, 1'b0);
    end

    // Reset applied before any clock edge: outputs must clear asynchronously
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("reset busy", busy_v[0], 1'b0);
    check("reset done", done_v[0], 1'b0);
    check("reset sum", sum0, 16'h0000);
    check("reset cout", cout_v[0], 1'b0);
    check("reset ovf", ovf_v[0], 1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Directed table on 16/4
    for (int i = 0; i < 7; i++) begin
      run_op(0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].s, vecs[i].c, rs, rc, ro, nb, ok);
      check($sformatf("vec%0d done", i), ok, 1'b1);
      check($sformatf("vec%0d busy_len", i), nb, 4);
      check($sformatf("vec%0d sum", i), rs, 32'(vecs[i].es));
      check($sformatf("vec%0d cout", i), rc, vecs[i].ec);
      check($sformatf("vec%0d ovf", i), ro, vecs[i].eo);
      @(negedge clock);
      check($sformatf("vec%0d done_pulse", i), done_v[0], 1'b0);
      check($sformatf("vec%0d idle", i), busy_v[0], 1'b0);
    end

    // start during RUN must be ignored
    @(negedge clock);
    drive(0, 32'h1111, 32'h2222, 1'b0, 1'b0);
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    @(negedge clock);
    drive(0, 32'hAAAA, 32'h5555, 1'b1, 1'b1);
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    wait_done(0, nb, ok);
    check("ignore done", ok, 1'b1);
    check("ignore sum", sum0, 16'h3333);
    check("ignore cout", cout_v[0], 1'b0);
    @(negedge clock);
    check("ignore no restart", busy_v[0], 1'b0);

    // Back-to-back: start held in the DONE cycle
    @(negedge clock);
    drive(0, 32'h1000, 32'h0234, 1'b0, 1'b0);
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    wait_done(0, nb, ok);
    check("b2b first done", ok, 1'b1);
    check("b2b first sum", sum0, 16'h1234);
    drive(0, 32'h8000, 32'h0001, 1'b1, 1'b0);
    start_v[0] = 1'b1;
    @(negedge clock);
    check("b2b busy rises", busy_v[0], 1'b1);
    start_v[0] = 1'b0;
    wait_done(0, nb, ok);
    check("b2b second done", ok, 1'b1);
    check("b2b busy_len", nb, 4);
    check("b2b second sum", sum0, 16'h7FFF);
    check("b2b second cout", cout_v[0], 1'b1);
    check("b2b second ovf", ovf_v[0], 1'b1);

    // Reset in RUN cycle 2 aborts, clears outputs asynchronously, no done
    @(negedge clock);
    drive(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    @(negedge clock);
    #($urandom_range(1, 3));
    reset_n = 1'b0;
    #1;
    check("abort busy", busy_v[0], 1'b0);
    check("abort done", done_v[0], 1'b0);
    check("abort sum", sum0, 16'h0000);
    check("abort cout", cout_v[0], 1'b0);
    check("abort ovf", ovf_v[0], 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done_v[0]) dcnt++;
      if (busy_v[0]) bcnt++;
    end
    check("abort no done", dcnt, 0);
    check("abort no busy", bcnt, 0);

    // Randomized ops on every configuration
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < ((k == 0) ? 200 : 1000); n++) begin
        ea   = rnd_val(wid[k]);
        eb   = rnd_val(wid[k]);
        rsub = 1'($urandom_range(0, 1));
        rcin = 1'($urandom_range(0, 1));
        model(wid[k], ea, eb, rsub, rcin, es, ec, eo);
        run_op(k, ea, eb, rsub, rcin, rs, rc, ro, nb, ok);
        check($sformatf("cfg%0d op%0d done", k, n), ok, 1'b1);
        check($sformatf("cfg%0d op%0d busy_len", k, n), nb, nbk[k]);
        check($sformatf("cfg%0d op%0d sum a=%0h b=%0h sub=%0b cin=%0b", k, n, ea, eb, rsub, rcin),
              rs, es);
        check($sformatf("cfg%0d op%0d cout", k, n), rc, ec);
        check($sformatf("cfg%0d op%0d ovf", k, n), ro, eo);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
